// File: rtl/uc_pkg.sv
// Shared types and constants for the uc_sequencer control unit.
package uc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED,
    ST_PAUSE
  } uc_state_e;

  // Instruction classes, taken from IR[15:13]
  localparam logic [2:0] CLS_ALU  = 3'b000;
  localparam logic [2:0] CLS_MOV  = 3'b001;
  localparam logic [2:0] CLS_LDI  = 3'b010;
  localparam logic [2:0] CLS_JMP  = 3'b011;
  localparam logic [2:0] CLS_JZ   = 3'b100;
  localparam logic [2:0] CLS_JC   = 3'b101;
  localparam logic [2:0] CLS_JN   = 3'b110;
  localparam logic [2:0] CLS_HALT = 3'b111;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_INC = 3'b100;
  localparam logic [2:0] OP_DEC = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/uc_decoder.sv
// Combinational field extraction and branch resolution for one instruction word.
module uc_decoder
  import uc_pkg::*;
(
  input  logic [15:0] ir_i,
  input  logic [2:0]  flags_i,
  output logic [2:0]  cls_o,
  output logic [2:0]  aluOp_o,
  output logic [2:0]  regY_o,
  output logic [2:0]  regX_o,
  output logic [2:0]  ldiDest_o,
  output logic [7:0]  imm_o,
  output logic        isBranch_o,
  output logic        takeBranch_o
);

  assign cls_o     = ir_i[15:13];
  assign aluOp_o   = ir_i[12:10];
  assign regY_o    = ir_i[9:7];
  assign regX_o    = ir_i[6:4];
  assign ldiDest_o = ir_i[12:10];
  assign imm_o     = ir_i[7:0];

  // Conditional jumps test the latched flag register passed in, not live ALU flags
  always_comb begin
    isBranch_o   = 1'b0;
    takeBranch_o = 1'b0;
    case (ir_i[15:13])
      CLS_JMP: begin
        isBranch_o   = 1'b1;
        takeBranch_o = 1'b1;
      end
      CLS_JZ: begin
        isBranch_o   = 1'b1;
        takeBranch_o = flags_i[FLAG_Z];
      end
      CLS_JC: begin
        isBranch_o   = 1'b1;
        takeBranch_o = flags_i[FLAG_C];
      end
      CLS_JN: begin
        isBranch_o   = 1'b1;
        takeBranch_o = flags_i[FLAG_N];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/uc_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control unit for the 8-bit core.
// Optional single-step mode (step input, PAUSE state) enabled by defining UC_STEP_EN.
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef UC_STEP_EN
  input  logic               step,
`endif
  output logic               pm_req,
  output logic [PC_W-1:0]    pm_addr,
  input  logic               pm_ack,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [2:0]         uc_oALU,
  output logic               math_hab,
  input  logic [2:0]         alu_flags,
  output logic [SEL_W-1:0]   rf_selX,
  output logic [SEL_W-1:0]   rf_selY,
  output logic [SEL_W-1:0]   rf_wsel,
  output logic               rf_we,
  output logic               rf_wsrc,
  output logic [7:0]         imm,
  output logic [2:0]         flags,
  output logic               busy,
  output logic               halted
);

`ifdef UC_STEP_EN
  localparam uc_state_e ST_RESUME = ST_PAUSE;
`else
  localparam uc_state_e ST_RESUME = ST_FETCH;
`endif

  uc_state_e           state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [2:0]          flags_q, flags_d;

  logic [2:0] cls, aluOp, regY, regX, ldiDest;
  logic [7:0] immV;
  logic       isBranch, takeBranch;

  uc_decoder u_decoder (
    .ir_i        (ir_q),
    .flags_i     (flags_q),
    .cls_o       (cls),
    .aluOp_o     (aluOp),
    .regY_o      (regY),
    .regX_o      (regX),
    .ldiDest_o   (ldiDest),
    .imm_o       (immV),
    .isBranch_o  (isBranch),
    .takeBranch_o(takeBranch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Datapath controls are only driven in EXECUTE/WRITEBACK so they stay identical across both
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flags_d  = flags_q;
    pm_req   = 1'b0;
    uc_oALU  = '0;
    math_hab = 1'b0;
    rf_selX  = '0;
    rf_selY  = '0;
    rf_wsel  = '0;
    rf_we    = 1'b0;
    rf_wsrc  = 1'b0;
    imm      = '0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        pm_req = 1'b1;
        if (pm_ack) begin
          ir_d    = pm_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (isBranch) begin
          if (takeBranch) pc_d = PC_W'(immV);
          state_d = ST_RESUME;
        end else if (cls == CLS_HALT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE, ST_WRITEBACK: begin
        case (cls)
          CLS_ALU: begin
            uc_oALU  = aluOp;
            math_hab = 1'b1;
            rf_selY  = SEL_W'(regY);
            rf_selX  = SEL_W'(regX);
            rf_wsel  = SEL_W'(regY);
          end
          CLS_MOV: begin
            rf_selY = SEL_W'(regX);
            rf_wsel = SEL_W'(regY);
          end
          CLS_LDI: begin
            rf_wsel = SEL_W'(ldiDest);
            rf_wsrc = 1'b1;
            imm     = immV;
          end
          default: ;
        endcase
        if (state_q == ST_WRITEBACK) begin
          rf_we = 1'b1;
          if (cls == CLS_ALU) flags_d = alu_flags;
          state_d = ST_RESUME;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
`ifdef UC_STEP_EN
      ST_PAUSE: if (step) state_d = ST_FETCH;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign pm_addr = pc_q;
  assign flags   = flags_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_uc_sequencer.sv
// Self-checking bench for uc_sequencer: an instruction-level model predicts
// fetch addresses, control outputs, flags and cycle timing under random programs.
module tb_uc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
`ifdef UC_STEP_EN
  logic        step;
`endif
  logic        pm_req;
  logic [7:0]  pm_addr;
  logic        pm_ack;
  logic [15:0] pm_data;
  logic [2:0]  uc_oALU;
  logic        math_hab;
  logic [2:0]  alu_flags;
  logic [2:0]  rf_selX, rf_selY, rf_wsel;
  logic        rf_we, rf_wsrc;
  logic [7:0]  imm;
  logic [2:0]  flags;
  logic        busy, halted;

  uc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef UC_STEP_EN
    .step     (step),
`endif
    .pm_req   (pm_req),
    .pm_addr  (pm_addr),
    .pm_ack   (pm_ack),
    .pm_data  (pm_data),
    .uc_oALU  (uc_oALU),
    .math_hab (math_hab),
    .alu_flags(alu_flags),
    .rf_selX  (rf_selX),
    .rf_selY  (rf_selY),
    .rf_wsel  (rf_wsel),
    .rf_we    (rf_we),
    .rf_wsrc  (rf_wsrc),
    .imm      (imm),
    .flags    (flags),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Architectural model: program memory, PC and flag register
  logic [15:0] mem [256];
  logic [7:0]  mPc;
  logic [2:0]  mFlags;
  int          checkCount = 0;
  int          errCount   = 0;
  bit          abortRun   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] outVec();
    return {uc_oALU, math_hab, rf_selX, rf_selY, rf_wsel, rf_wsrc, imm, rf_we};
  endfunction

  // Expected operand/control bundle for a non-branch instruction, straight from the field layout
  function automatic logic [22:0] expectVec(input logic [15:0] ins);
    case (ins[15:13])
      3'b000:  return {ins[12:10], 1'b1, ins[6:4], ins[9:7], ins[9:7], 1'b0, 8'h00, 1'b0};
      3'b001:  return {3'b000, 1'b0, 3'b000, ins[6:4], ins[9:7], 1'b0, 8'h00, 1'b0};
      3'b010:  return {3'b000, 1'b0, 3'b000, 3'b000, ins[12:10], 1'b1, ins[7:0], 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic afterOp();
`ifdef UC_STEP_EN
    checkOutput("pauseEnter", 32'({pm_req, busy, flags}), 32'({1'b0, 1'b1, mFlags}));
    tick();
    checkOutput("pauseHold", 32'({pm_req, busy}), 32'(2'b01));
    step = 1'b1;
    tick();
    step = 1'b0;
`else
    checkOutput("nextFetch", 32'({pm_req, busy, flags}), 32'({1'b1, 1'b1, mFlags}));
`endif
  endtask

  task automatic applyStimulus(input int ackDelay, input logic [2:0] af);
    logic [15:0] ins;
    logic [2:0]  cls;
    logic [22:0] expVec;
    logic        stable;
    int          waitCnt;
    pm_ack  = 1'b0;
    waitCnt = 0;
    while (pm_req !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("fetchSeen", 32'(pm_req), 32'(1));
    if (pm_req !== 1'b1) begin
      abortRun = 1;
      return;
    end
    checkOutput("fetchAddr", 32'(pm_addr), 32'(mPc));
    stable = 1'b1;
    for (int k = 0; k < ackDelay; k++) begin
      tick();
      stable &= (pm_req === 1'b1) && (pm_addr === mPc) && (busy === 1'b1);
    end
    if (ackDelay > 0) checkOutput("fetchHold", 32'(stable), 32'(1));
    ins     = mem[mPc];
    pm_data = ins;
    pm_ack  = 1'b1;
    start   = 1'($urandom_range(0, 1));
    tick();
    mPc       = mPc + 8'd1;
    pm_data   = 16'($urandom);
    alu_flags = ~mFlags;
    checkOutput("decode", 32'({pm_req, rf_we, busy, halted}), 32'(4'b0010));
    cls = ins[15:13];
    case (cls)
      3'b111: begin
        start = 1'b0;
        tick();
        checkOutput("halt", 32'({halted, busy, pm_req, rf_we}), 32'(4'b1000));
        tick();
        checkOutput("haltHold", 32'({halted, pm_req}), 32'(2'b10));
        start = 1'b1;
        tick();
        start = 1'b0;
        mPc   = 8'h00;
      end
      3'b011: begin
        mPc = ins[7:0];
        tick();
        afterOp();
      end
      3'b100, 3'b101, 3'b110: begin
        if (mFlags[cls[1:0]]) mPc = ins[7:0];
        tick();
        afterOp();
      end
      default: begin
        expVec = expectVec(ins);
        tick();
        checkOutput("execute", 32'(outVec()), 32'(expVec));
        alu_flags = af;
        tick();
        checkOutput("writeback", 32'(outVec()), 32'(expVec | 23'd1));
        if (cls == 3'b000) mFlags = af;
        tick();
        afterOp();
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
`ifdef UC_STEP_EN
    step      = 1'b0;
`endif
    pm_ack    = 1'b0;
    pm_data   = '0;
    alu_flags = '0;
    mPc       = 8'h00;
    mFlags    = 3'b000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    tick();
    tick();
    checkOutput("resetCtl", 32'({pm_req, pm_addr, flags, busy, halted}), 32'(0));
    checkOutput("resetDp", 32'(outVec()), 32'(0));
    rst_n = 1'b1;
    tick();
    checkOutput("idle", 32'({busy, halted, pm_req}), 32'(0));
    start = 1'b1;
    tick();
    start = 1'b0;

    mem[8'h00] = 16'h4405;
    mem[8'h01] = 16'h0530;
    mem[8'h02] = 16'h8020;
    mem[8'h20] = 16'h0530;
    mem[8'h21] = 16'h8040;
    mem[8'h22] = 16'h4405;
    mem[8'h23] = 16'hE000;
    applyStimulus(0, 3'b110);
    applyStimulus(0, 3'b001);
    applyStimulus(1, 3'b000);
    applyStimulus(0, 3'b000);
    applyStimulus(0, 3'b111);
    applyStimulus(3, 3'b010);
    applyStimulus(0, 3'b000);

    mem[8'h00] = 16'h60FF;
    mem[8'hFF] = 16'h2380;
    applyStimulus(0, 3'b000);
    applyStimulus(2, 3'b101);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 250 && !abortRun; n++)
      applyStimulus(int'($urandom_range(0, 3)), 3'($urandom));

    if (!abortRun) begin
      pm_ack = 1'b0;
      start  = 1'b0;
      for (int w = 0; w < 20 && pm_req !== 1'b1; w++) tick();
      mem[mPc] = 16'h4405;
      pm_data  = 16'h4405;
      pm_ack   = 1'b1;
      tick();
      pm_ack = 1'b0;
      tick();
      tick();
      checkOutput("wbBeforeReset", 32'(rf_we), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      checkOutput("resetAsync", 32'({rf_we, busy, rf_wsrc, imm, rf_wsel}), 32'(0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
Name: uc_sequencer

Overview:
- Multi-cycle control unit: the initiator side of the ALU control interface.
- Fetches 16-bit instructions from program memory over a req/ack handshake and decodes them.
- Drives ALU opcode, math enable and register-bank selects; consumes ALU flags for writeback and conditional branches.
- Sits between program memory, register bank and ALU in the 8-bit core.

Parameters:
PC_W, 8, program counter / program address width
INSTR_W, 16, instruction word width
SEL_W, 3, register select width (8 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; starts execution from IDLE or HALTED
pm_req  out  1  program memory fetch request
pm_addr  out  PC_W  fetch address (current PC)
pm_ack  in  1  fetch data valid; sampled only in FETCH
pm_data  in  INSTR_W  instruction word
uc_oALU  out  3  ALU opcode
math_hab  out  1  1 = ALU operation; 0 = pass RY through
alu_flags  in  3  ALU flags: [0]=Z, [1]=C, [2]=N
rf_selX  out  SEL_W  RX operand select
rf_selY  out  SEL_W  RY operand select
rf_wsel  out  SEL_W  write-back register select
rf_we  out  1  register write strobe, one cycle
rf_wsrc  out  1  0 = ALU result, 1 = immediate
imm  out  8  immediate value
flags  out  3  latched flag register
busy  out  1  high in any state except IDLE and HALTED
halted  out  1  high in HALTED

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, PC=0, IR=0, flags=0. All outputs 0. rf_we drops immediately, including mid-operation.
- Instruction classes, IR[15:13]:
  - 000 ALU: op=[12:10], Y/dest=[9:7], X=[6:4]
  - 001 MOV: dest=[9:7], src=[6:4], driven on selY
  - 010 LDI: dest=[12:10], imm=[7:0]
  - 011 JMP: target=[7:0]
  - 100 JZ, 101 JC, 110 JN: target=[7:0]
  - 111 HALT
- IDLE: start moves to FETCH.
- FETCH:
  - pm_req=1 and pm_addr=PC, both held stable until pm_ack.
  - On pm_ack: IR<=pm_data, PC<=PC+1 (wraps 0xFF->0x00), go to DECODE.
- DECODE, 1 cycle:
  - JMP: PC<=target, go to FETCH.
  - Jcc: if the selected flag bit is 1, PC<=target; in both cases go to FETCH.
  - HALT: go to HALTED.
  - Otherwise: go to EXECUTE.
- EXECUTE, 1 cycle:
  - Drive uc_oALU, selects, imm and rf_wsrc.
  - math_hab=1 for the ALU class only.
- WRITEBACK, 1 cycle:
  - rf_we=1; every select, opcode and math_hab value held identical to EXECUTE.
  - ALU class only: flags<=alu_flags. MOV and LDI leave flags unchanged.
  - Go to FETCH.
- HALTED: pm_req=0. start sets PC=0 and goes to FETCH.
- Latency, with pm_ack in the first FETCH cycle: ALU/MOV/LDI take 4 cycles; jumps take 2 cycles.
- Edge cases:
  - start while busy is ignored.
  - pm_ack outside FETCH is ignored.
  - Jcc uses the flags register, never the live alu_flags.

Optional Feature:
- UC_STEP_EN defined:
  - Adds input port step.
  - After each WRITEBACK or branch DECODE, the FSM enters PAUSE (busy=1, pm_req=0) and waits for a step pulse before going to FETCH.
  - step in other states is ignored.
- UC_STEP_EN undefined: no step port and no PAUSE state; behaviour exactly as above.

Decomposition:
- Package uc_pkg:
  - state enum (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, PAUSE)
  - instruction-class constants
  - ALU opcode constants (ADD=000 … XOR=111)
  - flag bit indices Z/C/N
- Sub-module uc_decoder: combinational IR field extraction and class decode, instantiated once.

Test Plan:
- Reset, start, LDI R1,0x05 (0x4405) with immediate pm_ack -> rf_we high exactly 1 cycle, 3 cycles after ack; rf_wsel=1, rf_wsrc=1, imm=0x05; flags unchanged.
- SUB R2,R3 (0x0530), bench drives alu_flags=3'b001 -> uc_oALU=001, math_hab=1, selY=2, selX=3 through EXECUTE and WRITEBACK; rf_wsel=2; flags=001 afterwards.
- JZ 0x20 (0x8020) -> with Z=1 the next pm_addr=0x20 and no rf_we; with Z=0 the next pm_addr=PC+1.
- pm_ack delayed 3 cycles -> pm_req and pm_addr stable for 4 cycles with no state advance. pm_ack pulsed during EXECUTE -> no effect.
- HALT (0xE000) -> halted=1, busy=0, pm_req=0; start -> fetch from 0x00. rst_n asserted mid-WRITEBACK -> rf_we=0 with no clock edge.
- JMP 0xFF (0x60FF), then MOV at 0xFF -> next fetch at 0x00. With UC_STEP_EN -> no fetch until the step pulse.
